uart_tx_arb: RTL
================

Name: uart_tx_arb

Overview:
- Shares one uart_tx instance between N byte-stream requesters, each sending packets framed by a last flag.
- Grants are round-robin and held for a whole packet. Per-grant burst limit and stall timeout prevent starvation.
- Presents the granted byte on the uart_tx data/rts inputs and completes each byte on the uart_tx cts pulse.
- Sits between firmware/protocol sources and uart_tx. Shares CLK and rst with uart_tx.

Parameters:
- N, 4, number of requesters (>=2).
- MAX_BURST, 0, max bytes per grant before forced release; 0 = unlimited (packet ends only on last).
- TIMEOUT, 65535, cycles the owner may stall in LOAD with req_valid low before grant is revoked; 0 = disabled.

Ports:
- CLK  in  1  system clock, single clock domain.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N  per-requester byte valid.
- req_data  in  8*N  byte of requester i at [8*i+7:8*i].
- req_last  in  N  byte is last of packet.
- req_ready  out  N  one-hot; transfer when req_valid[i] & req_ready[i].
- tx_data  out  8  to uart_tx data.
- tx_rts  out  1  to uart_tx rts.
- tx_cts  in  1  from uart_tx cts; one-cycle acceptance pulse.
- tx_active  in  1  from uart_tx tx_active; status only.
- grant_valid  out  1  a requester owns the UART.
- grant_id  out  max(1,clog2(N))  current/last owner index.
- busy  out  1  grant_valid | tx_active.
- timeout_evt  out  1  one-cycle pulse when a grant is revoked by TIMEOUT.

Behaviour:
- Reset (synchronous): state IDLE; tx_rts=0, tx_data=0, req_ready=0, grant_valid=0, timeout_evt=0; grant_id=0; last_grant=N-1, so requester 0 wins first; burst and stall counters = 0.
- FSM states: IDLE, LOAD, SEND.
- IDLE:
  - If any req_valid, winner = first set bit searching from last_grant+1 with wrap-around (N-1 wraps to 0).
  - Register owner=winner, grant_valid=1, burst=0, stall=0; go to LOAD next cycle.
  - One arbitration cycle; no req_ready is asserted in IDLE.
- LOAD:
  - req_ready = onehot(owner), combinational from state; all other bits 0.
  - If req_valid[owner]: capture byte into tx_data and last into a hold bit, set tx_rts=1, stall=0, go to SEND.
  - Else increment stall. If TIMEOUT!=0 and stall reaches TIMEOUT-1: go to IDLE, grant_valid=0, last_grant=owner, pulse timeout_evt.
- SEND:
  - tx_rts held 1; tx_data held stable; req_ready=0.
  - On tx_cts: tx_rts<=0 (registered, low the next cycle; uart_tx is then in START, so no double send); burst<=burst+1.
  - If hold_last, or MAX_BURST!=0 and burst+1==MAX_BURST: go to IDLE, grant_valid=0, last_grant=owner.
  - Otherwise go to LOAD.
- Latencies:
  - Request to first req_ready: 2 cycles (IDLE arbitrate, then LOAD).
  - Transfer to tx_rts high: 1 cycle.
  - Byte-to-byte rate is set by the uart_tx cts pulse; at most one outstanding byte.
- Other boundaries:
  - tx_cts outside SEND is ignored.
  - Non-owner req_valid never affects an active grant.
  - Owner dropping req_valid mid-packet keeps the grant (subject to TIMEOUT).
  - Forced release by MAX_BURST or TIMEOUT does not flush the requester; its remaining bytes go under a later grant.
  - Single requester always re-wins after release, via one IDLE cycle.
  - Simultaneous requests resolve per round-robin pointer only.
- Reset mid-SEND: tx_rts low the next cycle. uart_tx shares rst, so no orphaned byte.
- Widths: burst counter clog2(MAX_BURST+1) bits (min 1); stall counter clog2(TIMEOUT+1) bits (min 1); no wrap — both saturate at their limit.

Decomposition:
- Shared package (uart_pkg): state encodings ST_IDLE/ST_LOAD/ST_SEND, ID-width function, default baud constants.
- One sub-module: rr_pick, a combinational round-robin priority encoder (req vector, last_grant -> winner index, any). Reusable by a future RX demux.

Test Plan:
- Single packet: req0 sends 0x55, 0xA3(last) -> tx_data 0x55 then 0xA3. tx_rts drops the cycle after each cts; grant_valid falls after the second cts; grant_id=0.
- Contention: req0..3 all valid, one-byte packets (last=1) -> grant order 0,1,2,3,0. No req_ready asserted to a non-owner at any cycle.
- Packet atomicity: req1 sends a 3-byte packet while req2 is valid throughout -> all 3 req1 bytes complete before grant_id=2.
- MAX_BURST=2, req0 sends a 5-byte packet while req1 is valid -> order: req0 2 bytes, req1 packet, req0 bytes 3–4, req1 or re-arbitration per pointer, then the remaining byte.
- TIMEOUT=16: owner sends one byte (last=0) then drops valid -> timeout_evt pulses 16 cycles into the stall; grant passes to the next valid requester.
- Reset asserted while in SEND with tx_rts=1 -> the next cycle shows tx_rts=0, grant_valid=0, req_ready=0; post-reset first grant goes to requester 0.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared state encodings, id-width helper and default baud constants for the UART transmit path.
package uart_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SEND} arb_state_t;
    localparam int DEF_CLK_HZ = 50_000_000;
    localparam int DEF_BAUD   = 115_200;
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// rr_pick: combinational round-robin priority encoder, searching from last+1 with wrap-around.
module rr_pick
    import uart_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = id_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] idx,
    output logic          hit
);
    logic [N-1:0] rot;
    // rot[j] is requester (last+1+j) mod N, so the lowest set bit is the winner
    assign rot = N'({req, req} >> (int'(last) + 1));
    assign hit = |req;
    always_comb begin
        idx = '0;
        for (int j = N - 1; j >= 0; j--)
            if (rot[j]) idx = IW'((int'(last) + 1 + j) % N);
    end
endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: shares one uart_tx between N packet requesters with round-robin,
// packet-held grants, an optional per-grant burst limit and an optional stall timeout.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int N         = 4,
    parameter int MAX_BURST = 0,
    parameter int TIMEOUT   = 65535
) (
    input  logic                CLK,
    input  logic                rst,
    input  logic [N-1:0]        req_valid,
    input  logic [8*N-1:0]      req_data,
    input  logic [N-1:0]        req_last,
    output logic [N-1:0]        req_ready,
    output logic [7:0]          tx_data,
    output logic                tx_rts,
    input  logic                tx_cts,
    input  logic                tx_active,
    output logic                grant_valid,
    output logic [id_w(N)-1:0]  grant_id,
    output logic                busy,
    output logic                timeout_evt
);
    localparam int IW = id_w(N);
    localparam int BW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
    localparam int SW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    arb_state_t    state;
    logic [IW-1:0] last_grant;
    logic [IW-1:0] winner;
    logic          hit;
    logic [BW-1:0] burst;
    logic [SW-1:0] stall;
    logic          hold_last;
    logic          burst_end;

    rr_pick #(.N(N), .IW(IW)) u_pick (
        .req  (req_valid),
        .last (last_grant),
        .idx  (winner),
        .hit  (hit)
    );

    assign req_ready = (state == ST_LOAD) ? (N'(1) << grant_id) : '0;
    assign busy      = grant_valid | tx_active;
    assign burst_end = (MAX_BURST != 0) && (burst == BW'(MAX_BURST - 1));

    always_ff @(posedge CLK) begin
        timeout_evt <= 1'b0;
        if (rst) begin
            state       <= ST_IDLE;
            tx_rts      <= 1'b0;
            tx_data     <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            last_grant  <= IW'(N - 1);
            burst       <= '0;
            stall       <= '0;
            hold_last   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (hit) begin
                    grant_id    <= winner;
                    grant_valid <= 1'b1;
                    burst       <= '0;
                    stall       <= '0;
                    state       <= ST_LOAD;
                end
                ST_LOAD: if (req_valid[grant_id]) begin
                    tx_data   <= req_data[8*grant_id +: 8];
                    hold_last <= req_last[grant_id];
                    tx_rts    <= 1'b1;
                    stall     <= '0;
                    state     <= ST_SEND;
                end else if (TIMEOUT != 0 && stall == SW'(TIMEOUT - 1)) begin
                    state       <= ST_IDLE;
                    grant_valid <= 1'b0;
                    last_grant  <= grant_id;
                    timeout_evt <= 1'b1;
                end else if (stall != '1) begin
                    stall <= stall + 1'b1;
                end
                // uart_tx is in START once rts drops, so the byte cannot be sent twice
                ST_SEND: if (tx_cts) begin
                    tx_rts <= 1'b0;
                    if (burst != '1) burst <= burst + 1'b1;
                    if (hold_last || burst_end) begin
                        state       <= ST_IDLE;
                        grant_valid <= 1'b0;
                        last_grant  <= grant_id;
                    end else begin
                        state <= ST_LOAD;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
